cce_uc_msg_unit: RTL and testbench
==================================

// Module: cce_uc_msg_unit
// PURPOSE
// - Uncached-mode message engine of the CCE. Converts LCE uncached load/store requests into
//   memory commands, and memory responses into LCE commands (load data / store-done).
// - Sits between the CCE's buffered LCE request / memory response inputs (yumi handshake) and
//   the LCE command / memory command outputs (ready&valid). Selected by the CCE mode mux.
// - Keeps exactly one transaction outstanding at a time.
// PARAMETERS
// PADDR_W   40  physical address width
// DATA_W    64  data payload width; must be 64
// LCE_ID_W   4  LCE id width
// CCE_ID_W   3  CCE id width
// PORTS
// clk_i              in   1         clock
// reset_n_i          in   1         synchronous, active-low reset
// cce_id_i           in   CCE_ID_W  this CCE's id; used as the src of LCE commands
// lce_req_v_i        in   1         LCE request valid
// lce_req_wr_i       in   1         0 = uncached read, 1 = uncached write
// lce_req_src_i      in   LCE_ID_W  requesting LCE
// lce_req_addr_i     in   PADDR_W   request address
// lce_req_size_i     in   2         log2 bytes: 0=1B 1=2B 2=4B 3=8B
// lce_req_data_i     in   DATA_W    store data
// lce_req_yumi_o     out  1         request consumed
// mem_cmd_v_o        out  1         memory command valid
// mem_cmd_ready_i    in   1         memory accepts the command
// mem_cmd_type_o     out  4         4'd2 = UC_RD, 4'd3 = UC_WR
// mem_cmd_lce_o      out  LCE_ID_W  requester id, carried through memory
// mem_cmd_addr_o     out  PADDR_W   address
// mem_cmd_size_o     out  2         size
// mem_cmd_data_o     out  DATA_W    store data; 0 for reads
// mem_resp_v_i       in   1         memory response valid
// mem_resp_type_i    in   4         echoed command type
// mem_resp_lce_i     in   LCE_ID_W  echoed requester id
// mem_resp_addr_i    in   PADDR_W   echoed address
// mem_resp_data_i    in   DATA_W    load data
// mem_resp_yumi_o    out  1         response consumed
// lce_cmd_v_o        out  1         LCE command valid
// lce_cmd_ready_i    in   1         LCE accepts the command
// lce_cmd_type_o     out  4         4'd10 = UC_DATA, 4'd11 = UC_ST_DONE
// lce_cmd_dst_o      out  LCE_ID_W  destination LCE = mem_resp_lce_i
// lce_cmd_src_o      out  CCE_ID_W  = cce_id_i
// lce_cmd_addr_o     out  PADDR_W   = mem_resp_addr_i
// lce_cmd_data_o     out  DATA_W    load data; 0 for UC_ST_DONE
// outstanding_o      out  1         a memory command has been sent and its response not yet consumed
// err_misalign_o     out  1         sticky misalignment flag (see CONFIGURATION)
// BEHAVIOUR
// - States: IDLE, WAIT_RESP. Reset (reset_n_i=0 at a clock edge) -> IDLE, outstanding_o=0,
//   err_misalign_o=0. All valid and yumi outputs are 0 while reset_n_i=0.
// - IDLE: mem_cmd_v_o = lce_req_v_i. Fields pass through combinationally; type is UC_WR if
//   lce_req_wr_i is 1, else UC_RD; mem_cmd_data_o = 0 for reads.
//   lce_req_yumi_o = lce_req_v_i & mem_cmd_ready_i. On yumi -> WAIT_RESP; latency is 0 cycles.
// - IDLE: mem_resp_yumi_o = 0 and lce_cmd_v_o = 0. A stray response stays queued.
// - WAIT_RESP: lce_req_yumi_o = 0 and mem_cmd_v_o = 0. lce_cmd_v_o = mem_resp_v_i.
//   Type is UC_DATA if mem_resp_type_i is UC_RD, else UC_ST_DONE.
//   mem_resp_yumi_o = mem_resp_v_i & lce_cmd_ready_i. On yumi -> IDLE.
// - outstanding_o = (state == WAIT_RESP), registered.
// - Back-to-back operation: a new request can be accepted in the cycle after a response is
//   consumed, so the minimum spacing is 2 cycles per transaction.
// - Valid outputs never depend on ready inputs. Yumi is asserted only with the matching valid.
// - Reset mid-transaction drops the outstanding transaction. No command is replayed.
// CONFIGURATION
// - CCE_UC_ALIGN_CHECK_EN defined: when a request is accepted with addr[size-1:0] != 0
//   (i.e. addr mod 2^size != 0), err_misalign_o is set on the next edge and stays 1 until reset.
//   The request is still forwarded unchanged.
// - Macro undefined: err_misalign_o is tied to 0 and no check logic is built.
// TESTING
// - Read: req(rd, src=3, addr=0x1000, size=3), mem ready -> same-cycle UC_RD, lce=3, yumi=1;
//   resp data=0xDEADBEEF -> UC_DATA, dst=3, data=0xDEADBEEF, outstanding back to 0.
// - Write: req(wr, addr=0x2004, size=2, data=0x55) -> UC_WR, data=0x55;
//   resp -> UC_ST_DONE, data=0.
// - Backpressure: mem_cmd_ready_i=0 for 5 cycles -> no yumi, mem_cmd_v_o held at 1;
//   lce_cmd_ready_i=0 -> mem_resp_yumi_o=0 and lce_cmd_v_o held.
// - Second request during WAIT_RESP -> not consumed until the first response is delivered.
// - Reset (reset_n_i=0) asserted in WAIT_RESP -> IDLE, outstanding_o=0, all valids 0.
// - With CCE_UC_ALIGN_CHECK_EN: addr=0x1003, size=2 -> err_misalign_o=1 from the next cycle,
//   request still forwarded.

Source files
------------

// File: rtl/cce_uc_msg_unit.sv
// -----------------------------------------------------------------------------
// cce_uc_msg_unit
//
// Purpose:
//   Uncached-mode message engine of the CCE. It turns LCE uncached load/store
//   requests into memory commands, and memory responses into LCE commands
//   (load data or store-done). Only one transaction is outstanding at a time.
//   A request is forwarded in the same cycle it is presented (zero latency),
//   and a response is turned into an LCE command in the same cycle as well.
//
// Optional feature (compile-time macro CCE_UC_ALIGN_CHECK_EN):
//   When defined, accepting a request whose address is not aligned to its
//   access size sets the sticky err_misalign_o flag on the next edge. The flag
//   stays set until reset. The request is still forwarded unchanged.
//   When undefined, err_misalign_o is tied to 0 and no check logic is built.
//
// Ports:
//   clk_i, reset_n_i        clock, synchronous active-low reset
//   cce_id_i                this CCE's id, used as src of LCE commands
//   lce_req_*               buffered LCE request input (yumi handshake)
//   mem_cmd_*               memory command output (valid/ready)
//   mem_resp_*              buffered memory response input (yumi handshake)
//   lce_cmd_*               LCE command output (valid/ready)
//   outstanding_o           a memory command is in flight
//   err_misalign_o          sticky misalignment flag
//
// DATA_W must be 64.
// -----------------------------------------------------------------------------
module cce_uc_msg_unit #(
    parameter int PADDR_W  = 40,
    parameter int DATA_W   = 64,
    parameter int LCE_ID_W = 4,
    parameter int CCE_ID_W = 3
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic [CCE_ID_W-1:0] cce_id_i,

    input  logic                lce_req_v_i,
    input  logic                lce_req_wr_i,
    input  logic [LCE_ID_W-1:0] lce_req_src_i,
    input  logic [PADDR_W-1:0]  lce_req_addr_i,
    input  logic [1:0]          lce_req_size_i,
    input  logic [DATA_W-1:0]   lce_req_data_i,
    output logic                lce_req_yumi_o,

    output logic                mem_cmd_v_o,
    input  logic                mem_cmd_ready_i,
    output logic [3:0]          mem_cmd_type_o,
    output logic [LCE_ID_W-1:0] mem_cmd_lce_o,
    output logic [PADDR_W-1:0]  mem_cmd_addr_o,
    output logic [1:0]          mem_cmd_size_o,
    output logic [DATA_W-1:0]   mem_cmd_data_o,

    input  logic                mem_resp_v_i,
    input  logic [3:0]          mem_resp_type_i,
    input  logic [LCE_ID_W-1:0] mem_resp_lce_i,
    input  logic [PADDR_W-1:0]  mem_resp_addr_i,
    input  logic [DATA_W-1:0]   mem_resp_data_i,
    output logic                mem_resp_yumi_o,

    output logic                lce_cmd_v_o,
    input  logic                lce_cmd_ready_i,
    output logic [3:0]          lce_cmd_type_o,
    output logic [LCE_ID_W-1:0] lce_cmd_dst_o,
    output logic [CCE_ID_W-1:0] lce_cmd_src_o,
    output logic [PADDR_W-1:0]  lce_cmd_addr_o,
    output logic [DATA_W-1:0]   lce_cmd_data_o,

    output logic                outstanding_o,
    output logic                err_misalign_o
);

    localparam logic [3:0] MEM_UC_RD      = 4'd2;
    localparam logic [3:0] MEM_UC_WR      = 4'd3;
    localparam logic [3:0] LCE_UC_DATA    = 4'd10;
    localparam logic [3:0] LCE_UC_ST_DONE = 4'd11;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT_RESP
    } state_e;

    state_e state_q, state_d;

    // Payload fields are pure pass-throughs; only the valids are qualified
    // by state, so downstream logic must look at the valid first.
    assign mem_cmd_type_o = lce_req_wr_i ? MEM_UC_WR : MEM_UC_RD;
    assign mem_cmd_lce_o  = lce_req_src_i;
    assign mem_cmd_addr_o = lce_req_addr_i;
    assign mem_cmd_size_o = lce_req_size_i;
    assign mem_cmd_data_o = lce_req_wr_i ? lce_req_data_i : '0;

    assign lce_cmd_type_o = (mem_resp_type_i == MEM_UC_RD) ? LCE_UC_DATA : LCE_UC_ST_DONE;
    assign lce_cmd_dst_o  = mem_resp_lce_i;
    assign lce_cmd_src_o  = cce_id_i;
    assign lce_cmd_addr_o = mem_resp_addr_i;
    assign lce_cmd_data_o = (mem_resp_type_i == MEM_UC_RD) ? mem_resp_data_i : '0;

    // Handshake and next-state logic. Valids depend only on state and the
    // incoming valids; readies only feed the yumi outputs and the transition.
    // Everything is held low while reset is asserted so nothing is consumed
    // or issued during reset.
    always_comb begin
        state_d         = state_q;
        mem_cmd_v_o     = 1'b0;
        lce_req_yumi_o  = 1'b0;
        lce_cmd_v_o     = 1'b0;
        mem_resp_yumi_o = 1'b0;

        if (reset_n_i) begin
            case (state_q)
                ST_IDLE: begin
                    mem_cmd_v_o    = lce_req_v_i;
                    lce_req_yumi_o = lce_req_v_i & mem_cmd_ready_i;
                    if (lce_req_yumi_o) begin
                        state_d = ST_WAIT_RESP;
                    end
                end
                ST_WAIT_RESP: begin
                    lce_cmd_v_o     = mem_resp_v_i;
                    mem_resp_yumi_o = mem_resp_v_i & lce_cmd_ready_i;
                    if (mem_resp_yumi_o) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign outstanding_o = (state_q == ST_WAIT_RESP);

`ifdef CCE_UC_ALIGN_CHECK_EN
    logic       err_misalign_q, err_misalign_d;
    logic [2:0] size_mask;
    logic       req_misaligned;

    // Low address bits that must be zero for the requested access size.
    always_comb begin
        case (lce_req_size_i)
            2'd0:    size_mask = 3'b000;
            2'd1:    size_mask = 3'b001;
            2'd2:    size_mask = 3'b011;
            default: size_mask = 3'b111;
        endcase
        req_misaligned = |(lce_req_addr_i[2:0] & size_mask);
        err_misalign_d = err_misalign_q | (lce_req_yumi_o & req_misaligned);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            err_misalign_q <= 1'b0;
        end else begin
            err_misalign_q <= err_misalign_d;
        end
    end

    assign err_misalign_o = err_misalign_q;
`else
    assign err_misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_cce_uc_msg_unit.sv
// -----------------------------------------------------------------------------
// tb_cce_uc_msg_unit
//
// Self-checking bench for cce_uc_msg_unit. A transaction-level model (count of
// in-flight memory transactions plus the sticky error flag) predicts every
// output; a compare process checks the DUT against it on each falling edge.
// Directed vectors add hand-computed literal expectations.
// Inputs change 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_cce_uc_msg_unit;

    localparam int PADDR_W  = 40;
    localparam int DATA_W   = 64;
    localparam int LCE_ID_W = 4;
    localparam int CCE_ID_W = 3;

`ifdef CCE_UC_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic                clk;
    logic                reset_n;
    logic [CCE_ID_W-1:0] cce_id;
    logic                req_v, req_wr, req_yumi;
    logic [LCE_ID_W-1:0] req_src;
    logic [PADDR_W-1:0]  req_addr;
    logic [1:0]          req_size;
    logic [DATA_W-1:0]   req_data;
    logic                cmd_v, cmd_ready;
    logic [3:0]          cmd_type;
    logic [LCE_ID_W-1:0] cmd_lce;
    logic [PADDR_W-1:0]  cmd_addr;
    logic [1:0]          cmd_size;
    logic [DATA_W-1:0]   cmd_data;
    logic                resp_v, resp_yumi;
    logic [3:0]          resp_type;
    logic [LCE_ID_W-1:0] resp_lce;
    logic [PADDR_W-1:0]  resp_addr;
    logic [DATA_W-1:0]   resp_data;
    logic                lcmd_v, lcmd_ready;
    logic [3:0]          lcmd_type;
    logic [LCE_ID_W-1:0] lcmd_dst;
    logic [CCE_ID_W-1:0] lcmd_src;
    logic [PADDR_W-1:0]  lcmd_addr;
    logic [DATA_W-1:0]   lcmd_data;
    logic                outstanding, err_misalign;

    int checks   = 0;
    int failures = 0;

    cce_uc_msg_unit #(
        .PADDR_W(PADDR_W), .DATA_W(DATA_W), .LCE_ID_W(LCE_ID_W), .CCE_ID_W(CCE_ID_W)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .cce_id_i(cce_id),
        .lce_req_v_i(req_v), .lce_req_wr_i(req_wr), .lce_req_src_i(req_src),
        .lce_req_addr_i(req_addr), .lce_req_size_i(req_size), .lce_req_data_i(req_data),
        .lce_req_yumi_o(req_yumi),
        .mem_cmd_v_o(cmd_v), .mem_cmd_ready_i(cmd_ready), .mem_cmd_type_o(cmd_type),
        .mem_cmd_lce_o(cmd_lce), .mem_cmd_addr_o(cmd_addr), .mem_cmd_size_o(cmd_size),
        .mem_cmd_data_o(cmd_data),
        .mem_resp_v_i(resp_v), .mem_resp_type_i(resp_type), .mem_resp_lce_i(resp_lce),
        .mem_resp_addr_i(resp_addr), .mem_resp_data_i(resp_data), .mem_resp_yumi_o(resp_yumi),
        .lce_cmd_v_o(lcmd_v), .lce_cmd_ready_i(lcmd_ready), .lce_cmd_type_o(lcmd_type),
        .lce_cmd_dst_o(lcmd_dst), .lce_cmd_src_o(lcmd_src), .lce_cmd_addr_o(lcmd_addr),
        .lce_cmd_data_o(lcmd_data),
        .outstanding_o(outstanding), .err_misalign_o(err_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int m_inflight = 0;   // memory transactions issued and not yet answered
    bit m_err      = 1'b0;

    function automatic bit misaligned(input logic [PADDR_W-1:0] a, input logic [1:0] s);
        longint unsigned bytes;
        bytes = longint'(1) << s;
        return (longint'(a) % bytes) != 0;
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            m_inflight <= 0;
            m_err      <= 1'b0;
        end else if (m_inflight == 0 && req_v && cmd_ready) begin
            m_inflight <= 1;
            if (ALIGN_EN && misaligned(req_addr, req_size)) m_err <= 1'b1;
        end else if (m_inflight != 0 && resp_v && lcmd_ready) begin
            m_inflight <= 0;
        end
    end

    // Compare process: every output against the model, every cycle.
    always @(negedge clk) begin
        logic can_issue, can_reply;
        can_issue = reset_n && (m_inflight == 0);
        can_reply = reset_n && (m_inflight != 0);
        chk("m_outstanding", outstanding, (m_inflight != 0));
        chk("m_err", err_misalign, m_err);
        chk("m_cmd_v", cmd_v, can_issue && req_v);
        chk("m_req_yumi", req_yumi, can_issue && req_v && cmd_ready);
        chk("m_lcmd_v", lcmd_v, can_reply && resp_v);
        chk("m_resp_yumi", resp_yumi, can_reply && resp_v && lcmd_ready);
        if (cmd_v) begin
            chk("m_cmd_type", cmd_type, req_wr ? 4'd3 : 4'd2);
            chk("m_cmd_lce", cmd_lce, req_src);
            chk("m_cmd_addr", cmd_addr, req_addr);
            chk("m_cmd_size", cmd_size, req_size);
            chk("m_cmd_data", cmd_data, req_wr ? req_data : 64'd0);
        end
        if (lcmd_v) begin
            chk("m_lcmd_type", lcmd_type, (resp_type == 4'd2) ? 4'd10 : 4'd11);
            chk("m_lcmd_dst", lcmd_dst, resp_lce);
            chk("m_lcmd_src", lcmd_src, cce_id);
            chk("m_lcmd_addr", lcmd_addr, resp_addr);
            chk("m_lcmd_data", lcmd_data, (resp_type == 4'd2) ? resp_data : 64'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic wr, input logic [3:0] src, input logic [39:0] addr,
                           input logic [1:0] size, input logic [63:0] data);
        req_v = 1'b1; req_wr = wr; req_src = src; req_addr = addr;
        req_size = size; req_data = data;
    endtask

    task automatic set_resp(input logic [3:0] typ, input logic [3:0] lce,
                            input logic [39:0] addr, input logic [63:0] data);
        resp_v = 1'b1; resp_type = typ; resp_lce = lce; resp_addr = addr; resp_data = data;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset_n = 1'b0; cce_id = 3'd5;
        req_v = 0; req_wr = 0; req_src = 0; req_addr = 0; req_size = 0; req_data = 0;
        cmd_ready = 0; resp_v = 0; resp_type = 0; resp_lce = 0; resp_addr = 0; resp_data = 0;
        lcmd_ready = 0;

        // Reset with every input active: nothing may be issued or consumed.
        set_req(1'b0, 4'd1, 40'h10, 2'd0, 64'd0);
        set_resp(4'd2, 4'd1, 40'h10, 64'd1);
        cmd_ready = 1; lcmd_ready = 1;
        repeat (3) tick();
        #1;
        chk("rst_cmd_v", cmd_v, 1'b0);
        chk("rst_req_yumi", req_yumi, 1'b0);
        chk("rst_lcmd_v", lcmd_v, 1'b0);
        chk("rst_resp_yumi", resp_yumi, 1'b0);
        chk("rst_outstanding", outstanding, 1'b0);
        chk("rst_err", err_misalign, 1'b0);
        reset_n = 1'b1; req_v = 0; resp_v = 0;
        tick();

        // Uncached read.
        set_req(1'b0, 4'd3, 40'h1000, 2'd3, 64'hFFFF);
        #1;
        chk("rd_cmd_v", cmd_v, 1'b1);
        chk("rd_cmd_type", cmd_type, 4'd2);
        chk("rd_cmd_lce", cmd_lce, 4'd3);
        chk("rd_cmd_data", cmd_data, 64'd0);
        chk("rd_req_yumi", req_yumi, 1'b1);
        tick(); req_v = 0;
        #1 chk("rd_outstanding", outstanding, 1'b1);
        set_resp(4'd2, 4'd3, 40'h1000, 64'hDEADBEEF);
        #1;
        chk("rd_lcmd_type", lcmd_type, 4'd10);
        chk("rd_lcmd_dst", lcmd_dst, 4'd3);
        chk("rd_lcmd_src", lcmd_src, 3'd5);
        chk("rd_lcmd_data", lcmd_data, 64'hDEADBEEF);
        chk("rd_resp_yumi", resp_yumi, 1'b1);
        tick(); resp_v = 0;
        #1 chk("rd_outstanding_clr", outstanding, 1'b0);

        // Uncached write.
        set_req(1'b1, 4'd6, 40'h2004, 2'd2, 64'h55);
        #1;
        chk("wr_cmd_type", cmd_type, 4'd3);
        chk("wr_cmd_data", cmd_data, 64'h55);
        chk("wr_req_yumi", req_yumi, 1'b1);
        tick(); req_v = 0;
        set_resp(4'd3, 4'd6, 40'h2004, 64'h1234);
        #1;
        chk("wr_lcmd_type", lcmd_type, 4'd11);
        chk("wr_lcmd_data", lcmd_data, 64'd0);
        chk("wr_lcmd_dst", lcmd_dst, 4'd6);
        tick(); resp_v = 0;

        // Memory command backpressure for 5 cycles.
        set_req(1'b0, 4'd7, 40'h3008, 2'd3, 64'd0);
        cmd_ready = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_cmd_v", cmd_v, 1'b1);
            chk("bp_req_yumi", req_yumi, 1'b0);
            tick();
        end
        cmd_ready = 1;
        #1 chk("bp_release_yumi", req_yumi, 1'b1);
        tick();

        // Second request held during WAIT_RESP, plus LCE command backpressure.
        set_req(1'b1, 4'd2, 40'h4000, 2'd3, 64'hABCD);
        set_resp(4'd2, 4'd7, 40'h3008, 64'hCAFE);
        lcmd_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp2_resp_yumi", resp_yumi, 1'b0);
            chk("bp2_lcmd_v", lcmd_v, 1'b1);
            chk("bp2_req_yumi", req_yumi, 1'b0);
            chk("bp2_cmd_v", cmd_v, 1'b0);
            tick();
        end
        lcmd_ready = 1;
        #1 chk("bp2_resp_yumi_rel", resp_yumi, 1'b1);
        tick(); resp_v = 0;
        #1;
        chk("b2b_req_yumi", req_yumi, 1'b1);
        chk("b2b_cmd_addr", cmd_addr, 40'h4000);
        chk("b2b_cmd_data", cmd_data, 64'hABCD);
        tick(); req_v = 0;
        #1 chk("b2b_outstanding", outstanding, 1'b1);

        // Reset in WAIT_RESP drops the transaction.
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        #1;
        chk("midrst_outstanding", outstanding, 1'b0);
        chk("midrst_cmd_v", cmd_v, 1'b0);

        // Stray response in IDLE stays queued.
        set_resp(4'd3, 4'd2, 40'h4000, 64'd0);
        #1;
        chk("stray_resp_yumi", resp_yumi, 1'b0);
        chk("stray_lcmd_v", lcmd_v, 1'b0);
        tick(); resp_v = 0;
        #1 chk("stray_outstanding", outstanding, 1'b0);

        // Misaligned request: forwarded; flag only with the check built in.
        set_req(1'b1, 4'd4, 40'h1003, 2'd2, 64'h77);
        #1;
        chk("mis_cmd_addr", cmd_addr, 40'h1003);
        chk("mis_req_yumi", req_yumi, 1'b1);
        chk("mis_err_before", err_misalign, 1'b0);
        tick(); req_v = 0;
        #1 chk("mis_err_after", err_misalign, ALIGN_EN);
        set_resp(4'd3, 4'd4, 40'h1003, 64'd0);
        tick(); resp_v = 0;
        tick();
        #1 chk("mis_err_sticky", err_misalign, ALIGN_EN);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
